// File: rtl/draw_scheduler.sv
// draw_scheduler: sequences border/ball/paddle draw clients once per frame and muxes
// the granted client's pixel writes onto the single VGA write port.
module draw_scheduler #(
   parameter int FRAME_CYCLES = 833333,
   parameter int TIMEOUT      = 4095
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic [3:0]  go_out,
   input  logic [3:0]  done_in,
   input  logic [3:0]  plot_in,
   input  logic [31:0] x_in,
   input  logic [27:0] y_in,
   input  logic [11:0] colour_in,
   output logic        plot_out,
   output logic [7:0]  x_out,
   output logic [6:0]  y_out,
   output logic [2:0]  colour_out,
   output logic [1:0]  grant,
   output logic        busy,
   output logic        frame_tick,
   output logic [2:0]  err
);
   localparam int FW = $clog2(FRAME_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, START, RUN, NEXT, WAIT_FRAME} state_t;

   state_t        state, state_n;
   logic [1:0]    idx, idx_n;
   logic          border_drawn, border_n;
   logic          tick_pending, pend_n;
   logic [2:0]    err_n;
   logic [FW-1:0] fcnt;
   logic [TW-1:0] tcnt, tcnt_n;
   logic          run;
   logic [3:0]    sel;

   assign run        = state == RUN;
   assign sel        = 4'b0001 << idx;
   assign frame_tick = fcnt == FW'(FRAME_CYCLES - 1);
   assign go_out     = state == START ? sel : 4'b0000;
   assign grant      = idx;
   assign busy       = state != IDLE;
   assign plot_out   = run & plot_in[idx];
   assign x_out      = run ? x_in[{idx, 3'b000} +: 8] : 8'd0;
   assign y_out      = run ? y_in[5'(idx) * 5'd7 +: 7] : 7'd0;
   assign colour_out = run ? colour_in[4'(idx) * 4'd3 +: 3] : 3'd0;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state        <= IDLE;
         idx          <= 2'd0;
         border_drawn <= 1'b0;
         tick_pending <= 1'b0;
         err          <= 3'b000;
         fcnt         <= '0;
         tcnt         <= '0;
      end else begin
         state        <= state_n;
         idx          <= idx_n;
         border_drawn <= border_n;
         tick_pending <= pend_n;
         err          <= err_n;
         fcnt         <= frame_tick ? '0 : fcnt + 1'b1;
         tcnt         <= tcnt_n;
      end

   always_comb begin
      state_n  = state;
      idx_n    = idx;
      border_n = border_drawn;
      pend_n   = tick_pending;
      err_n    = err;
      tcnt_n   = tcnt;
      if (frame_tick && state != WAIT_FRAME) begin
         pend_n   = 1'b1;
         err_n[1] = 1'b1;
      end
      if (|(plot_in & ~(run ? sel : 4'b0000)))
         err_n[2] = 1'b1;
      case (state)
         IDLE:
            if (enable) begin
               state_n = START;
               idx_n   = border_drawn ? 2'd1 : 2'd0;
            end
         START: begin
            tcnt_n  = '0;
            state_n = RUN;
         end
         RUN:
            // done wins over a timeout landing in the same cycle
            if (done_in[idx])
               state_n = NEXT;
            else if (tcnt == TW'(TIMEOUT - 1)) begin
               err_n[0] = 1'b1;
               state_n  = NEXT;
            end else
               tcnt_n = tcnt + 1'b1;
         NEXT: begin
            if (idx == 2'd0)
               border_n = 1'b1;
            if (!enable)
               state_n = IDLE;
            else begin
               state_n = idx == 2'd3 ? WAIT_FRAME : START;
               idx_n   = idx == 2'd3 ? 2'd1 : idx + 2'd1;
            end
         end
         WAIT_FRAME:
            if (!enable)
               state_n = IDLE;
            else if (frame_tick || tick_pending) begin
               pend_n  = 1'b0;
               state_n = START;
            end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler: scoreboarded go_out sequencing plus a vector table for the
// RUN-phase pixel mux, with FRAME_CYCLES=64 and TIMEOUT=16.
module tb_draw_scheduler;
   logic        clk = 1'b0, reset = 1'b1, enable = 1'b0;
   logic [3:0]  go_out, done_in, plot_in = 4'b0;
   logic [31:0] x_in = '0;
   logic [27:0] y_in = '0;
   logic [11:0] colour_in = '0;
   logic        plot_out, busy, frame_tick;
   logic [7:0]  x_out;
   logic [6:0]  y_out;
   logic [2:0]  colour_out, err;
   logic [1:0]  grant;

   int tests = 0, fails = 0, cyc = 0;
   int dly[4];
   logic [5:0] cnt[4];

   typedef struct {logic [3:0] go; int at;} go_t;
   go_t exp_q[$];
   go_t e;

   typedef struct {
      logic [3:0] plot; logic [31:0] x; logic [27:0] y; logic [11:0] c;
      logic ep; logic [7:0] ex; logic [6:0] ey; logic [2:0] ec; logic ee;
   } vec_t;
   vec_t tbl[6];

   draw_scheduler #(.FRAME_CYCLES(64), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .enable(enable), .go_out(go_out), .done_in(done_in),
      .plot_in(plot_in), .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
      .plot_out(plot_out), .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
      .grant(grant), .busy(busy), .frame_tick(frame_tick), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge reset)
      cyc <= reset ? 0 : cyc + 1;

   // each client raises done for one cycle, dly cycles after its go (dly=0: never)
   always @(posedge clk or posedge reset)
      for (int i = 0; i < 4; i++)
         cnt[i] <= reset ? 6'd0 : go_out[i] ? 6'(dly[i]) : cnt[i] != 0 ? cnt[i] - 6'd1 : 6'd0;
   assign done_in = {cnt[3] == 1, cnt[2] == 1, cnt[1] == 1, cnt[0] == 1};

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk)
      if (!reset) begin
         chk("frame_tick", frame_tick, cyc % 64 == 63);
         if (go_out != 4'b0) begin
            if (exp_q.size() == 0)
               chk("unexpected go", go_out, 0);
            else begin
               e = exp_q.pop_front();
               chk("go value", go_out, e.go);
               chk("go cycle", cyc, e.at);
            end
         end
      end

   task automatic push(logic [3:0] g, int at);
      exp_q.push_back('{g, at});
   endtask

   task automatic set_dly(int a, int b, int c, int d);
      dly[0] = a; dly[1] = b; dly[2] = c; dly[3] = d;
   endtask

   task automatic do_reset();
      enable = 1'b0; plot_in = '0; x_in = '0; y_in = '0; colour_in = '0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst go_out", go_out, 0);
      chk("rst busy", busy, 0);
      chk("rst grant", grant, 0);
      chk("rst err", err, 0);
      chk("rst plot_out", plot_out, 0);
      chk("rst frame_tick", frame_tick, 0);
      exp_q.delete();
      reset = 1'b0;
      enable = 1'b1;
   endtask

   task automatic wait_cyc(int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic end_scn(string name);
      chk({name, " missing go"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{4'b0000, 32'h0000_5000, 28'h0, 12'h0, 1'b0, 8'd80, 7'd0, 3'd0, 1'b0};
      tbl[1] = '{4'b0010, {8'd1, 8'd2, 8'd80, 8'd4}, {7'd9, 7'd8, 7'd42, 7'd3},
                 {3'd1, 3'd2, 3'd5, 3'd6}, 1'b1, 8'd80, 7'd42, 3'd5, 1'b0};
      tbl[2] = '{4'b0010, {8'd10, 8'd20, 8'd255, 8'd40}, {7'd1, 7'd2, 7'd127, 7'd4},
                 {3'd0, 3'd0, 3'd7, 3'd0}, 1'b1, 8'd255, 7'd127, 3'd7, 1'b0};
      tbl[3] = '{4'b0000, {8'd7, 8'd6, 8'd0, 8'd5}, {7'd100, 7'd99, 7'd0, 7'd98},
                 {3'd7, 3'd7, 3'd0, 3'd7}, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0};
      tbl[4] = '{4'b0100, 32'h0000_5000, 28'h0, 12'h0, 1'b0, 8'd80, 7'd0, 3'd0, 1'b0};
      tbl[5] = '{4'b0000, 32'h0, 28'h0, 12'h0, 1'b0, 8'd0, 7'd0, 3'd0, 1'b1};

      // full sweep, idle in WAIT_FRAME, then ball onward without border
      set_dly(5, 5, 5, 5);
      do_reset();
      push(4'b0001, 1); push(4'b0010, 8); push(4'b0100, 15); push(4'b1000, 22); push(4'b0010, 64);
      wait_cyc(40);
      chk("wait busy", busy, 1);
      chk("wait grant", grant, 1);
      wait_cyc(66);
      chk("sweep err", err, 0);
      end_scn("sweep");

      // RUN-phase pixel mux vectors with client 1 granted
      set_dly(5, 0, 5, 5);
      do_reset();
      push(4'b0001, 1); push(4'b0010, 8);
      wait_cyc(9);
      for (int i = 0; i < 6; i++) begin
         plot_in = tbl[i].plot; x_in = tbl[i].x; y_in = tbl[i].y; colour_in = tbl[i].c;
         #1;
         chk($sformatf("vec%0d plot_out", i), plot_out, tbl[i].ep);
         chk($sformatf("vec%0d x_out", i), x_out, tbl[i].ex);
         chk($sformatf("vec%0d y_out", i), y_out, tbl[i].ey);
         chk($sformatf("vec%0d colour_out", i), colour_out, tbl[i].ec);
         chk($sformatf("vec%0d err2", i), err[2], tbl[i].ee);
         chk($sformatf("vec%0d grant", i), grant, 1);
         @(negedge clk);
      end
      plot_in = '0; x_in = '0; y_in = '0; colour_in = '0;
      end_scn("mux");

      // client 2 never finishes: timeout then paddle follows two cycles later
      set_dly(5, 5, 0, 5);
      do_reset();
      push(4'b0001, 1); push(4'b0010, 8); push(4'b0100, 15); push(4'b1000, 33);
      wait_cyc(31);
      chk("pre-timeout err", err, 3'b000);
      chk("pre-timeout grant", grant, 2);
      wait_cyc(32);
      chk("timeout err", err, 3'b001);
      wait_cyc(40);
      plot_in = 4'b1000; x_in = 32'hFFFF_FFFF;
      #1;
      chk("idle plot_out", plot_out, 0);
      chk("idle x_out", x_out, 0);
      @(negedge clk);
      plot_in = '0; x_in = '0;
      #1;
      chk("stray plot err", err, 3'b101);
      end_scn("timeout");

      // done on the very last RUN cycle counts as done
      set_dly(5, 5, 16, 5);
      do_reset();
      push(4'b0001, 1); push(4'b0010, 8); push(4'b0100, 15); push(4'b1000, 33);
      wait_cyc(34);
      chk("edge-done err", err, 3'b000);
      end_scn("edge-done");

      // slow clients overrun the frame; pending tick restarts the sweep at once
      set_dly(30, 30, 30, 30);
      do_reset();
      push(4'b0001, 1); push(4'b0010, 19); push(4'b0100, 37); push(4'b1000, 55); push(4'b0010, 74);
      wait_cyc(64);
      chk("overrun err", err, 3'b011);
      wait_cyc(78);
      end_scn("overrun");

      // disable mid-client: client completes, returns to IDLE, resumes at ball
      set_dly(5, 5, 5, 5);
      do_reset();
      push(4'b0001, 1); push(4'b0010, 8); push(4'b0010, 21);
      wait_cyc(10);
      enable = 1'b0;
      wait_cyc(13);
      chk("finishing busy", busy, 1);
      wait_cyc(15);
      chk("disabled busy", busy, 0);
      chk("disabled grant", grant, 1);
      wait_cyc(20);
      enable = 1'b1;
      wait_cyc(24);
      end_scn("disable");

      // asynchronous reset mid-RUN drops the grant and forces a border redraw
      set_dly(5, 5, 5, 5);
      do_reset();
      push(4'b0001, 1); push(4'b0010, 8);
      wait_cyc(10);
      plot_in = 4'b0010; x_in = 32'h0000_4500;
      #1;
      chk("pre-reset plot_out", plot_out, 1);
      chk("pre-reset x_out", x_out, 8'h45);
      #1 reset = 1'b1;
      #1;
      chk("async plot_out", plot_out, 0);
      chk("async x_out", x_out, 0);
      chk("async busy", busy, 0);
      chk("async grant", grant, 0);
      end_scn("pre-reset");
      @(negedge clk);
      plot_in = '0; x_in = '0;
      reset = 1'b0;
      push(4'b0001, 1);
      wait_cyc(4);
      chk("post-reset err", err, 3'b000);
      end_scn("post-reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 The module SHALL have parameter FRAME_CYCLES, default 833333, meaning clocks per frame period (60 Hz at 50 MHz).
REQ-002 The module SHALL have parameter TIMEOUT, default 4095, meaning the maximum number of RUN cycles granted to one client before abort.
REQ-003 The module SHALL have port clk  input  1  meaning the system clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset  input  1  meaning asynchronous, active-high reset.
REQ-005 The module SHALL have port enable  input  1  meaning run scheduling.
REQ-006 The module SHALL have port go_out  output  4  meaning one-hot, single-cycle start pulse to each client: 0=border, 1=ball, 2=bottom paddle, 3=top paddle.
REQ-007 The module SHALL have port done_in  input  4  meaning a client finished drawing.
REQ-008 The module SHALL have port plot_in  input  4  meaning per-client write request.
REQ-009 The module SHALL have port x_in  input  32  meaning the packed 8-bit x per client; client i uses bits [8i+7:8i].
REQ-010 The module SHALL have port y_in  input  28  meaning the packed 7-bit y per client.
REQ-011 The module SHALL have port colour_in  input  12  meaning the packed 3-bit colour per client.
REQ-012 The module SHALL have port plot_out, x_out, y_out, colour_out  output  1/8/7/3  meaning the arbitrated pixel write to the VGA adapter.
REQ-013 The module SHALL have port grant  output  2  meaning the index of the current client.
REQ-014 The module SHALL have port busy  output  1  meaning the FSM is not in IDLE.
REQ-015 The module SHALL have port frame_tick  output  1  meaning a one-cycle pulse at frame counter wrap.
REQ-016 The module SHALL have port err  output  3  meaning sticky error bits: [0] timeout, [1] frame overrun, [2] plot by a non-granted client.

Function
REQ-017 The FSM SHALL have states IDLE, START, RUN, NEXT and WAIT_FRAME.
REQ-018 IDLE: when enable=1, the FSM SHALL go to START with idx=0 if the border has not been drawn since reset, else with idx=1.
REQ-019 START: the FSM SHALL assert go_out[idx]=1 for exactly one cycle, clear the timeout counter and go to RUN.
REQ-020 RUN: plot_out, x_out, y_out and colour_out SHALL equal the idx slice of the inputs combinationally, with zero latency.
REQ-021 RUN: on done_in[idx]=1 the FSM SHALL go to NEXT; go_out for the next client SHALL assert two cycles after done is sampled.
REQ-022 RUN: the timeout counter SHALL increment each cycle; on reaching TIMEOUT without done, the FSM SHALL set err[0] and go to NEXT (client abandoned).
REQ-023 NEXT: when idx=0, the FSM SHALL set border_drawn and continue with idx=1 in START.
REQ-024 NEXT: when idx is 1 or 2, the FSM SHALL increment idx and go to START.
REQ-025 NEXT: when idx=3, the FSM SHALL set idx=1 and go to WAIT_FRAME.
REQ-026 NEXT: if enable=0, the FSM SHALL go to IDLE instead; the current client always completes first.
REQ-027 WAIT_FRAME: on frame_tick or tick_pending, the FSM SHALL clear tick_pending and go to START.
REQ-028 WAIT_FRAME: if enable=0, the FSM SHALL go to IDLE.
REQ-029 The frame counter SHALL free-run from reset over 0..FRAME_CYCLES-1, independent of enable; frame_tick SHALL be 1 in the cycle the count equals FRAME_CYCLES-1.
REQ-030 A frame_tick outside WAIT_FRAME SHALL set tick_pending (one deep) and err[1]; a second tick while tick_pending is set SHALL be dropped and err[1] SHALL remain set.
REQ-031 Outside RUN, plot_out SHALL be 0 and x_out, y_out and colour_out SHALL be 0.
REQ-032 Any plot_in[j]=1 with j≠idx, or any plot_in bit set outside RUN, SHALL be ignored and SHALL set err[2].
REQ-033 done_in bits of non-granted clients SHALL be ignored.
REQ-034 done_in[idx] asserted in the same cycle the timeout is reached SHALL be treated as done, with no error.
REQ-035 grant SHALL hold idx in every state; busy SHALL be 1 in every state except IDLE.

Reset
REQ-036 On reset=1, regardless of clock, the FSM SHALL go to IDLE and idx, border_drawn, tick_pending, err, the frame counter, the timeout counter and go_out SHALL be 0.
REQ-037 Reset mid-RUN SHALL drop the grant immediately (plot_out=0), and the border SHALL be redrawn on the next enable.

Verification (FRAME_CYCLES=64, TIMEOUT=16)
REQ-038 Release reset with enable=1 and each client raising done 5 cycles after go -> go_out sequence 0001, 0010, 0100, 1000; then idle until frame_tick at cycle 63; then 0010 (border not repeated).
REQ-039 In RUN with grant=1, drive plot_in=0010 and x_in[15:8]=8'd80 -> plot_out=1, x_out=80 in the same cycle; plot_in=0100 -> plot_out=0 and err[2]=1.
REQ-040 Client 2 never raises done -> after 16 RUN cycles err[0]=1 and go_out=1000 follows within 2 cycles.
REQ-041 Clients take 30 cycles each, so a sweep exceeds 64 cycles -> err[1]=1, tick_pending consumed, next sweep starts from WAIT_FRAME without waiting.
REQ-042 Deassert enable during client 1 RUN -> client 1 finishes; then IDLE, busy=0; re-enable -> first go_out=0010.
REQ-043 Assert reset mid-RUN -> outputs zero asynchronously; after release and enable -> first go_out=0001.
